// File: rtl/rtc_timer_slew.sv
// PTP real-time clock: seconds + ns + ns_fraction accumulator with delta-sigma period dithering,
// time-bounded slew adjustment, snapshot capture and a one-second pulse.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | nominal period only, waiting for adj_ld
// ST_SLEW | period offset by adj_delta, cnt_q counts remaining cycles
module rtc_timer_slew #(
   parameter  int SEC_W   = 48,
   parameter  int NS_W    = 30,
   parameter  int FRAC_W  = 8,
   parameter  int PFRAC_W = 32,
   parameter  int CNT_W   = 32,
   localparam int T_W     = NS_W + FRAC_W,
   localparam int P_W     = 8 + PFRAC_W,
   localparam int DS_W    = PFRAC_W - FRAC_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             time_ld,
   input  logic [T_W-1:0]   time_reg_ns_in,
   input  logic [SEC_W-1:0] time_reg_sec_in,
   input  logic             period_ld,
   input  logic [P_W-1:0]   period_in,
   input  logic [T_W-1:0]   time_acc_modulo,
   input  logic             adj_ld,
   input  logic [CNT_W-1:0] adj_cycles,
   input  logic [P_W-1:0]   adj_delta,
   input  logic             adj_abort,
   output logic             adj_busy,
   input  logic             snap_req,
   output logic             snap_valid,
   output logic [T_W-1:0]   snap_ns,
   output logic [SEC_W-1:0] snap_sec,
   output logic             pps_out,
   output logic [T_W-1:0]   time_reg_ns,
   output logic [SEC_W-1:0] time_reg_sec
);

   localparam int ST_W = P_W + 1 - DS_W;

   typedef enum logic {ST_IDLE = 1'b0, ST_SLEW = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [P_W-1:0]   delta_q, delta_d;
   logic [P_W-1:0]   period_fix_q, period_fix_d;
   logic [P_W-1:0]   inc_q, inc_d;
   logic [DS_W-1:0]  residue_q, residue_d;
   logic [T_W-1:0]   ns_q, ns_d;
   logic [SEC_W-1:0] sec_q, sec_d;
   logic             pps_q, pps_d;
   logic             snap_valid_q, snap_valid_d;
   logic [T_W-1:0]   snap_ns_q, snap_ns_d;
   logic [SEC_W-1:0] snap_sec_q, snap_sec_d;

   logic [P_W+1:0]   inc_raw;
   logic [P_W:0]     ds_sum;
   logic [ST_W-1:0]  step;
   logic [T_W:0]     ns_sum;

   // Abort outranks a (re)start request arriving in the same cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      delta_d = delta_q;
      if (adj_abort) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (adj_ld && (adj_cycles != '0)) begin
         state_d = ST_SLEW;
         cnt_d   = adj_cycles;
         delta_d = adj_delta;
      end else if (state_q == ST_SLEW) begin
         cnt_d = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
         end
      end
   end

   // Two guard bits: bit P_W+1 flags a negative sum, bit P_W an overflow.
   always_comb begin
      period_fix_d = period_ld ? period_in : period_fix_q;
      inc_raw      = {2'b00, period_fix_q};
      if (state_q == ST_SLEW) begin
         inc_raw = inc_raw + {{2{delta_q[P_W-1]}}, delta_q};
      end
      if (inc_raw[P_W+1]) begin
         inc_d = '0;
      end else if (inc_raw[P_W]) begin
         inc_d = '1;
      end else begin
         inc_d = inc_raw[P_W-1:0];
      end
   end

   always_comb begin
      ds_sum    = {1'b0, inc_q} + {{(P_W+1-DS_W){1'b0}}, residue_q};
      step      = ds_sum[P_W:DS_W];
      ns_sum    = {1'b0, ns_q} + {{(T_W+1-ST_W){1'b0}}, step};
      residue_d = ds_sum[DS_W-1:0];
      ns_d      = ns_sum[T_W-1:0];
      sec_d     = sec_q;
      pps_d     = 1'b0;
      if (time_ld) begin
         ns_d      = time_reg_ns_in;
         sec_d     = time_reg_sec_in;
         residue_d = '0;
      end else if (ns_sum >= {1'b0, time_acc_modulo}) begin
         ns_d  = ns_sum[T_W-1:0] - time_acc_modulo;
         sec_d = sec_q + SEC_W'(1);
         pps_d = 1'b1;
      end
      snap_valid_d = snap_req;
      snap_ns_d    = snap_req ? ns_q  : snap_ns_q;
      snap_sec_d   = snap_req ? sec_q : snap_sec_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         delta_q      <= '0;
         period_fix_q <= '0;
         inc_q        <= '0;
         residue_q    <= '0;
         ns_q         <= '0;
         sec_q        <= '0;
         pps_q        <= 1'b0;
         snap_valid_q <= 1'b0;
         snap_ns_q    <= '0;
         snap_sec_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         delta_q      <= delta_d;
         period_fix_q <= period_fix_d;
         inc_q        <= inc_d;
         residue_q    <= residue_d;
         ns_q         <= ns_d;
         sec_q        <= sec_d;
         pps_q        <= pps_d;
         snap_valid_q <= snap_valid_d;
         snap_ns_q    <= snap_ns_d;
         snap_sec_q   <= snap_sec_d;
      end
   end

   assign adj_busy     = (state_q == ST_SLEW);
   assign snap_valid   = snap_valid_q;
   assign snap_ns      = snap_ns_q;
   assign snap_sec     = snap_sec_q;
   assign pps_out      = pps_q;
   assign time_reg_ns  = ns_q;
   assign time_reg_sec = sec_q;

endmodule
